// File: rtl/dmux14_pkt_dispatch.sv
// Packet dispatcher: routes a framed valid/ready stream to one of four ports
// through a one-deep output register, dropping packets to disabled ports.
module dmux14_pkt_dispatch #(
    parameter int DW   = 8,
    parameter int CNTW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        port_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [1:0]        in_dest,
    input  logic              in_last,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic [4*CNTW-1:0] pkt_cnt,
    output logic [CNTW-1:0]   drop_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             route_q, route_d;
    logic [3:0]             out_valid_q, out_valid_d;
    logic [DW-1:0]          out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic [3:0][CNTW-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNTW-1:0]        drop_cnt_q, drop_cnt_d;

    logic occ, drain, accept, load, drop_done;

    always_comb begin
        occ       = |out_valid_q;
        drain     = occ & out_ready[route_q];
        in_ready  = (state_q == DROP) ? 1'b1 : (~occ | out_ready[route_q]);
        accept    = in_valid & in_ready;
        state_d   = state_q;
        route_d   = route_q;
        load      = 1'b0;
        drop_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (port_en[in_dest]) begin
                        load    = 1'b1;
                        route_d = in_dest;
                        state_d = in_last ? IDLE : FWD;
                    end else if (in_last) begin
                        drop_done = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            FWD: begin
                if (accept) begin
                    load = 1'b1;
                    if (in_last) state_d = IDLE;
                end
            end
            DROP: begin
                if (accept && in_last) begin
                    drop_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (load) begin
            out_valid_d = 4'b0001 << route_d;
            out_data_d  = in_data;
            out_last_d  = in_last;
        end else if (drain) begin
            out_valid_d = 4'b0000;
        end

        // Counters saturate; delivery and drop may both bump in one cycle.
        pkt_cnt_d = pkt_cnt_q;
        if (drain && out_last_q && pkt_cnt_q[route_q] != '1)
            pkt_cnt_d[route_q] = pkt_cnt_q[route_q] + CNTW'(1);
        drop_cnt_d = drop_cnt_q;
        if (drop_done && drop_cnt_q != '1)
            drop_cnt_d = drop_cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            route_q     <= 2'd0;
            out_valid_q <= 4'b0000;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = (state_q != IDLE) | occ;

endmodule

// File: tb/tb_dmux14_pkt_dispatch.sv
// Directed bench for dmux14_pkt_dispatch with hand-computed expectations.
module tb_dmux14_pkt_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  port_en;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_dest;
    logic        in_last;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [31:0] pkt_cnt;
    logic [7:0]  drop_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmux14_pkt_dispatch #(.DW(8), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .port_en(port_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dest(in_dest), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] d,
                         input logic [7:0] x, input logic l);
        in_valid = v;
        in_dest  = d;
        in_data  = x;
        in_last  = l;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        port_en   = 4'hF;
        out_ready = 4'hF;
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_pkt", pkt_cnt, 32'h0);
        check("rst_drop", 32'(drop_cnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);

        // single-beat packet to port 2
        drive(1'b1, 2'd2, 8'hA5, 1'b1);
        check("t1_rdy", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        check("t1_valid", 32'(out_valid), 32'h4);
        check("t1_data", 32'(out_data), 32'hA5);
        check("t1_last", 32'(out_last), 32'h1);
        step();
        check("t1_cnt2", 32'(pkt_cnt[23:16]), 32'h1);
        check("t1_drain", 32'(out_valid), 32'h0);

        // 3-beat packet to port 1 with stall and toggling in_dest
        drive(1'b1, 2'd1, 8'h11, 1'b0);
        step();
        check("t2_v1", 32'(out_valid), 32'h2);
        out_ready = 4'b1101;
        drive(1'b1, 2'd3, 8'h22, 1'b0);
        check("t2_stall_rdy0", 32'(in_ready), 32'h0);
        step();
        check("t2_hold_data0", 32'(out_data), 32'h11);
        check("t2_stall_rdy1", 32'(in_ready), 32'h0);
        step();
        check("t2_hold_data1", 32'(out_data), 32'h11);
        check("t2_hold_valid", 32'(out_valid), 32'h2);
        out_ready = 4'hF;
        #1;
        check("t2_rdy_back", 32'(in_ready), 32'h1);
        step();
        check("t2_b2_data", 32'(out_data), 32'h22);
        check("t2_b2_valid", 32'(out_valid), 32'h2);
        drive(1'b1, 2'd0, 8'h33, 1'b1);
        step();
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        check("t2_b3_data", 32'(out_data), 32'h33);
        check("t2_b3_valid", 32'(out_valid), 32'h2);
        check("t2_b3_last", 32'(out_last), 32'h1);
        step();
        check("t2_cnt1", 32'(pkt_cnt[15:8]), 32'h1);

        // 4-beat packet to disabled port 0 is dropped
        port_en = 4'b1110;
        drive(1'b1, 2'd0, 8'h40, 1'b0);
        check("t3_rdy0", 32'(in_ready), 32'h1);
        step();
        check("t3_valid0", 32'(out_valid), 32'h0);
        check("t3_busy", 32'(busy), 32'h1);
        out_ready = 4'h0;
        drive(1'b1, 2'd1, 8'h41, 1'b0);
        check("t3_rdy1", 32'(in_ready), 32'h1);
        step();
        drive(1'b1, 2'd2, 8'h42, 1'b0);
        check("t3_rdy2", 32'(in_ready), 32'h1);
        step();
        drive(1'b1, 2'd1, 8'h43, 1'b1);
        check("t3_rdy3", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        check("t3_drop", 32'(drop_cnt), 32'h1);
        check("t3_valid", 32'(out_valid), 32'h0);
        check("t3_idle", 32'(busy), 32'h0);
        out_ready = 4'hF;
        port_en   = 4'hF;

        // back-to-back single-beat packets 0,3,0,3
        drive(1'b1, 2'd0, 8'h50, 1'b1);
        step();
        check("t4_v0", 32'(out_valid), 32'h1);
        drive(1'b1, 2'd3, 8'h51, 1'b1);
        check("t4_rdy1", 32'(in_ready), 32'h1);
        step();
        check("t4_v1", 32'(out_valid), 32'h8);
        check("t4_d1", 32'(out_data), 32'h51);
        drive(1'b1, 2'd0, 8'h52, 1'b1);
        check("t4_rdy2", 32'(in_ready), 32'h1);
        step();
        check("t4_v2", 32'(out_valid), 32'h1);
        drive(1'b1, 2'd3, 8'h53, 1'b1);
        check("t4_rdy3", 32'(in_ready), 32'h1);
        step();
        check("t4_v3", 32'(out_valid), 32'h8);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        step();
        check("t4_cnt0", 32'(pkt_cnt[7:0]), 32'h2);
        check("t4_cnt3", 32'(pkt_cnt[31:24]), 32'h2);

        // saturation of pkt_cnt[3]
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 2'd3, 8'(i), 1'b1);
            step();
        end
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        step();
        check("t5_sat3", 32'(pkt_cnt[31:24]), 32'hFF);
        check("t5_drop", 32'(drop_cnt), 32'h1);

        // async reset in the middle of a forwarded packet
        drive(1'b1, 2'd2, 8'h60, 1'b0);
        step();
        check("t6_pre", 32'(out_valid), 32'h4);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 32'h0);
        check("t6_pkt", pkt_cnt, 32'h0);
        check("t6_drop", 32'(drop_cnt), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        drive(1'b1, 2'd1, 8'h61, 1'b1);
        step();
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        check("t6_route", 32'(out_valid), 32'h2);
        check("t6_data", 32'(out_data), 32'h61);
        step();
        check("t6_cnt1", 32'(pkt_cnt[15:8]), 32'h1);
        check("t6_cnt2", 32'(pkt_cnt[23:16]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
